// File: rtl/vad_segment_reader_if.sv
// Downstream sample stream: valid/ready handshake with segment first/last markers.
interface vad_segment_reader_if;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_last;

    modport master (output m_data, m_valid, m_first, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_first, m_last, output m_ready);
endinterface

// File: rtl/vad_segment_reader.sv
// Read-side controller for the VAD-gated circular buffer: trims to pre-roll while
// idle, streams pre-roll plus live audio as one segment per VAD burst.
module vad_segment_reader #(
    parameter int BUFFER_SIZE = 24000,
    parameter int PREROLL     = 4000,
    parameter int HANGOVER    = 4800,
    parameter int MAX_SEG     = 24000,
    parameter int CNT_WIDTH   = $clog2(BUFFER_SIZE+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_buf_write,
    input  logic [15:0]           i_buf_data,
    input  logic                  i_buf_empty,
    output logic                  o_buf_read,
    input  logic                  i_vad_active,
    vad_segment_reader_if.master  m_if,
    output logic                  o_busy,
    output logic                  o_overflow
);
    localparam int SEG_W  = $clog2(MAX_SEG+1);
    localparam int HANG_W = $clog2(HANGOVER+1);

    typedef enum logic [1:0] {IDLE, STREAM, HANG, WAIT_LOW} state_t;

    state_t              r_state, w_next;
    logic [CNT_WIDTH-1:0] r_level;
    logic [SEG_W-1:0]    r_seg_cnt;
    logic [HANG_W-1:0]   r_hang_cnt;
    logic                r_first_pend;
    logic [15:0]         r_data;
    logic                r_valid, r_first, r_last, r_overflow;

    logic w_full, w_can_pop, w_fwd, w_disc, w_last, w_seg_hit, w_hang_hit;

    // A write into a full buffer makes it ignore a simultaneous read as well.
    assign w_full    = (r_level == CNT_WIDTH'(BUFFER_SIZE));
    assign w_can_pop = (r_level != '0) && !(i_buf_write && w_full);

    always_comb begin
        w_next     = r_state;
        w_fwd      = 1'b0;
        w_disc     = 1'b0;
        w_seg_hit  = 1'b0;
        w_hang_hit = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            IDLE: begin
                w_disc = w_can_pop && (r_level > CNT_WIDTH'(PREROLL));
                if (i_vad_active) w_next = STREAM;
            end
            WAIT_LOW: begin
                w_disc = w_can_pop && (r_level > CNT_WIDTH'(PREROLL));
                if (!i_vad_active) w_next = IDLE;
            end
            STREAM, HANG: begin
                w_fwd      = w_can_pop && (!r_valid || m_if.m_ready);
                w_seg_hit  = w_fwd && (r_seg_cnt == SEG_W'(MAX_SEG-1));
                w_hang_hit = w_fwd && (r_state == HANG) && (r_hang_cnt == HANG_W'(1));
                w_last     = w_seg_hit || w_hang_hit;
                if (w_seg_hit)                               w_next = WAIT_LOW;
                else if (w_hang_hit)                         w_next = IDLE;
                else if (r_state == STREAM && !i_vad_active) w_next = HANG;
                else if (r_state == HANG && i_vad_active)    w_next = STREAM;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_buf_read = w_fwd || w_disc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_level      <= '0;
            r_seg_cnt    <= '0;
            r_hang_cnt   <= '0;
            r_first_pend <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_overflow <= i_buf_write && !o_buf_read && w_full;
            case ({i_buf_write, o_buf_read})
                2'b10:   if (!w_full) r_level <= r_level + CNT_WIDTH'(1);
                2'b01:   r_level <= r_level - CNT_WIDTH'(1);
                default: ;
            endcase

            if (r_state == IDLE && w_next == STREAM) begin
                r_seg_cnt    <= '0;
                r_first_pend <= 1'b1;
            end else if (w_fwd) begin
                r_seg_cnt    <= r_seg_cnt + SEG_W'(1);
                r_first_pend <= 1'b0;
            end

            // A pop in STREAM on the cycle VAD drops does not count toward hangover.
            if (r_state == STREAM && w_next == HANG) r_hang_cnt <= HANG_W'(HANGOVER);
            else if (r_state == HANG && w_fwd)       r_hang_cnt <= r_hang_cnt - HANG_W'(1);

            if (w_fwd) begin
                r_data  <= i_buf_data;
                r_valid <= 1'b1;
                r_first <= r_first_pend;
                r_last  <= w_last;
            end else if (m_if.m_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_if.m_data  = r_data;
    assign m_if.m_valid = r_valid;
    assign m_if.m_first = r_first;
    assign m_if.m_last  = r_last;
    assign o_busy       = (r_state == STREAM) || (r_state == HANG);
    assign o_overflow   = r_overflow;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert (i_buf_empty == (r_level == '0));
    end
`endif
endmodule

// File: tb/tb_vad_segment_reader.sv
// Bench: behavioural buffer queue plus segment-level reference of the reader, random traffic.
module tb_vad_segment_reader;
    localparam int BS = 16, PRE = 4, HO = 3, MS = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_buf_write, i_buf_empty, o_buf_read, i_vad_active, o_busy, o_overflow;
    logic [15:0] i_buf_data;

    vad_segment_reader_if bus();

    vad_segment_reader #(.BUFFER_SIZE(BS), .PREROLL(PRE), .HANGOVER(HO), .MAX_SEG(MS)) dut (
        .clk(clk), .rst(rst), .i_buf_write(i_buf_write), .i_buf_data(i_buf_data),
        .i_buf_empty(i_buf_empty), .o_buf_read(o_buf_read), .i_vad_active(i_vad_active),
        .m_if(bus), .o_busy(o_busy), .o_overflow(o_overflow));

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: buffer contents and what the reader should be doing
    logic [15:0] fifo[$];
    bit          seg_on, wait_low, first_pend;
    int          hang_left, seg_n;
    bit          mv, mf, ml, ov;
    logic [15:0] md;
    logic [15:0] wdat;

    // directed observation
    bit          rec, exp_ov, exp_no_rd;
    logic [15:0] acc_d[$];
    bit          acc_f[$], acc_l[$];

    task automatic model_clear();
        fifo.delete();
        seg_on = 0; wait_low = 0; first_pend = 0; hang_left = 0; seg_n = 0;
        mv = 0; mf = 0; ml = 0; ov = 0; md = '0;
    endtask

    task automatic drive_buf();
        i_buf_data  = (fifo.size() > 0) ? fifo[0] : 16'h0;
        i_buf_empty = (fifo.size() == 0);
    endtask

    task automatic cyc(input bit w, input bit v, input bit r);
        int lvl; bit can, p_fwd, p_disc, last_now, was_hang;
        logic [15:0] head;
        i_buf_write = w; i_vad_active = v; bus.m_ready = r;
        lvl    = fifo.size();
        can    = (lvl > 0) && !(w && lvl == BS);
        p_fwd  = seg_on && can && (!mv || r);
        p_disc = !seg_on && can && (lvl > PRE);
        head   = (lvl > 0) ? fifo[0] : 16'h0;
        #1;
        chk("buf_read", o_buf_read, p_fwd || p_disc);
        chk("m_valid", bus.m_valid, mv);
        if (mv) begin
            chk("m_data", bus.m_data, md);
            chk("m_first", bus.m_first, mf);
            chk("m_last", bus.m_last, ml);
        end
        chk("busy", o_busy, seg_on);
        chk("overflow", o_overflow, ov);
        if (exp_ov)    chk("ovf_pulse", o_overflow, 1);
        if (exp_no_rd) chk("rd_at_full", o_buf_read, 0);
        if (rec && bus.m_valid && r) begin
            acc_d.push_back(bus.m_data); acc_f.push_back(bus.m_first); acc_l.push_back(bus.m_last);
        end
        @(posedge clk);
        last_now = p_fwd && ((seg_n + 1 == MS) || (hang_left == 1));
        if (p_fwd) begin md = head; mv = 1; mf = first_pend; ml = last_now; end
        else if (r) mv = 0;
        ov = w && (lvl == BS);
        if (seg_on) begin
            was_hang = (hang_left > 0);
            if (p_fwd) begin
                seg_n++; first_pend = 0;
                if (was_hang) hang_left--;
            end
            if (p_fwd && seg_n == MS)     begin seg_on = 0; hang_left = 0; wait_low = 1; end
            else if (last_now)            begin seg_on = 0; hang_left = 0; end
            else if (!was_hang && !v)     hang_left = HO;
            else if (was_hang && v)       hang_left = 0;
        end else if (wait_low) begin
            if (!v) wait_low = 0;
        end else if (v) begin
            seg_on = 1; seg_n = 0; first_pend = 1;
        end
        if (p_fwd || p_disc) void'(fifo.pop_front());
        if (w && (lvl < BS || p_fwd || p_disc)) begin
            fifo.push_back(wdat); wdat++;
        end
        @(negedge clk);
        drive_buf();
    endtask

    task automatic do_reset();
        rst = 1; i_buf_write = 0; i_vad_active = 0; bus.m_ready = 1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        drive_buf();
        rst = 0;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_first", bus.m_first, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_buf_read", o_buf_read, 0);
    endtask

    initial begin
        int nf, nl, k;
        rec = 0; exp_ov = 0; exp_no_rd = 0; wdat = 16'd1;
        i_buf_data = '0; i_buf_empty = 1;
        do_reset();

        // pre-roll trim, onset, hangover
        wdat = 16'd1;
        repeat (10) cyc(1, 0, 1);
        repeat (3)  cyc(0, 0, 1);
        rec = 1;
        repeat (6)  cyc(1, 1, 1);
        repeat (4)  cyc(1, 0, 1);
        repeat (4)  cyc(0, 0, 1);
        rec = 0;
        chk("seg1_len", acc_d.size(), 9);
        for (int i = 0; i < acc_d.size() && i < 9; i++) begin
            chk("seg1_data", acc_d[i], 7 + i);
            chk("seg1_first", acc_f[i], i == 0);
            chk("seg1_last", acc_l[i], i == 8);
        end
        chk("seg1_idle", o_busy, 0);

        // backpressure mid-stream
        repeat (4)  cyc(1, 1, 1);
        repeat (5)  cyc(1, 1, 0);
        repeat (3)  cyc(1, 1, 1);
        repeat (12) cyc(1, 0, 1);
        repeat (6)  cyc(0, 0, 1);

        // MAX_SEG, then no retrigger until VAD goes low
        acc_d.delete(); acc_f.delete(); acc_l.delete();
        rec = 1;
        repeat (20) cyc(1, 1, 1);
        repeat (6)  cyc(0, 1, 1);
        rec = 0;
        nf = 0; nl = 0;
        foreach (acc_f[i]) begin nf += acc_f[i]; nl += acc_l[i]; end
        chk("maxseg_len", acc_d.size(), MS);
        chk("maxseg_firsts", nf, 1);
        chk("maxseg_lasts", nl, 1);
        if (acc_l.size() == MS) chk("maxseg_last_pos", acc_l[MS-1], 1);
        repeat (4) cyc(0, 0, 1);
        acc_f.delete(); acc_d.delete(); acc_l.delete();
        rec = 1;
        repeat (6) cyc(1, 1, 1);
        rec = 0;
        nf = 0;
        foreach (acc_f[i]) nf += acc_f[i];
        chk("retrigger_first", nf, 1);
        repeat (10) cyc(1, 0, 1);
        repeat (6)  cyc(0, 0, 1);

        // fill to full with reads blocked, overflow, write+ready at full
        k = 0;
        while (fifo.size() < BS && k < 40) begin cyc(1, 1, 0); k++; end
        chk("fill_bound", fifo.size(), BS);
        cyc(1, 1, 0);
        exp_ov = 1; exp_no_rd = 1;
        cyc(1, 1, 1);
        exp_ov = 0; exp_no_rd = 0;
        repeat (5) cyc(0, 1, 1);

        // reset in the middle of a segment
        do_reset();

        // random traffic
        i_vad_active = 0;
        begin
            bit v = 0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(39) == 0) v = ~v;
                if ($urandom_range(599) == 0) do_reset();
                else cyc($urandom_range(99) < 70, v, $urandom_range(99) < 75);
            end
        end
        repeat (30) cyc(0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
